// File: rtl/ahb_pkg.sv
// rtl/ahb_pkg.sv - AHB-Lite encodings and loader state type
package ahb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [2:0] HSIZE_WORD    = 3'b010;
  localparam logic [2:0] HBURST_SINGLE = 3'b000;
  localparam logic [3:0] HPROT_DATA    = 4'b0011;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FILL,
    ST_ADDR,
    ST_DATA,
    ST_DONE,
    ST_ERR
  } loader_state_t;

endpackage

// File: rtl/byte_packer.sv
// rtl/byte_packer.sv - little-endian byte to word packer feeding the AHB write FSM
module byte_packer (
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        fill_en,
  input  logic        s_valid,
  input  logic [7:0]  s_data,
  input  logic        s_last,
  output logic        s_ready,
  output logic        word_valid,
  output logic [31:0] word,
  output logic        word_last,
  input  logic        word_taken
);

  logic [1:0]  idx_q;
  logic [31:0] buf_q;
  logic        last_q;
  logic        accept;

  assign s_ready    = fill_en;
  assign accept     = s_valid && fill_en;
  // Pulses on the accept that completes a word so the FSM leaves FILL on that same edge
  assign word_valid = accept && ((idx_q == 2'd3) || s_last);
  assign word       = buf_q;
  assign word_last  = last_q;

  always_ff @(posedge clk) begin
    if (rst || clear || word_taken) begin
      idx_q  <= 2'd0;
      buf_q  <= 32'd0;
      last_q <= 1'b0;
    end else if (accept) begin
      buf_q[{idx_q, 3'b000} +: 8] <= s_data;
      idx_q                       <= idx_q + 2'd1;
      last_q                      <= s_last;
    end
  end

endmodule

// File: rtl/ahb_stream_loader.sv
// rtl/ahb_stream_loader.sv - byte stream to AHB-Lite single NONSEQ word write loader
module ahb_stream_loader #(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DATA_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = 32'h0000_0000,
  parameter logic [ADDR_WIDTH-1:0] LAST_ADDR  = 32'h0000_FFFF
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  start,
  input  logic                  s_valid,
  input  logic [7:0]            s_data,
  input  logic                  s_last,
  output logic                  s_ready,
  output logic [ADDR_WIDTH-1:0] haddr,
  output logic [DATA_WIDTH-1:0] hwdata,
  output logic                  hwrite,
  output logic [1:0]            htrans,
  output logic [2:0]            hsize,
  output logic [2:0]            hburst,
  output logic [3:0]            hprot,
  output logic                  hmastlock,
  input  logic                  hready,
  input  logic                  hresp,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic [15:0]           word_count
);
  import ahb_pkg::*;

  loader_state_t         state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d, haddr_q, haddr_d;
  logic [DATA_WIDTH-1:0] hwdata_q, hwdata_d;
  logic [1:0]            htrans_q, htrans_d;
  logic                  hwrite_q, hwrite_d;
  logic [15:0]           count_q, count_d;
  logic                  done_q, done_d, error_q, error_d;
  logic                  clear, word_taken;
  logic                  pk_valid, pk_last;
  logic [31:0]           pk_word;
  logic [ADDR_WIDTH:0]   addr_end;
  logic                  addr_ovf;

  byte_packer u_packer (
    .clk        (CLK),
    .rst        (RST),
    .clear      (clear),
    .fill_en    (state_q == ST_FILL),
    .s_valid    (s_valid),
    .s_data     (s_data),
    .s_last     (s_last),
    .s_ready    (s_ready),
    .word_valid (pk_valid),
    .word       (pk_word),
    .word_last  (pk_last),
    .word_taken (word_taken)
  );

  // One extra bit so the last-byte check cannot itself wrap
  assign addr_end = {1'b0, addr_q} + (ADDR_WIDTH + 1)'(3);
  assign addr_ovf = addr_end > {1'b0, LAST_ADDR};

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    haddr_d    = haddr_q;
    hwdata_d   = hwdata_q;
    htrans_d   = HTRANS_IDLE;
    hwrite_d   = 1'b0;
    count_d    = count_q;
    done_d     = done_q;
    error_d    = error_q;
    clear      = 1'b0;
    word_taken = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE, ST_ERR: begin
        if (start) begin
          state_d = ST_FILL;
          addr_d  = BASE_ADDR;
          count_d = 16'd0;
          done_d  = 1'b0;
          error_d = 1'b0;
          clear   = 1'b1;
        end
      end
      ST_FILL: begin
        if (pk_valid) begin
          state_d = ST_ADDR;
          // Address phase is registered, so it is launched on the edge that enters ADDR
          if (!addr_ovf) begin
            htrans_d = HTRANS_NONSEQ;
            hwrite_d = 1'b1;
            haddr_d  = addr_q;
          end
        end
      end
      ST_ADDR: begin
        if (addr_ovf) begin
          state_d = ST_ERR;
          error_d = 1'b1;
        end else if (hready) begin
          state_d  = ST_DATA;
          hwdata_d = pk_word;
        end else begin
          htrans_d = HTRANS_NONSEQ;
          hwrite_d = 1'b1;
        end
      end
      ST_DATA: begin
        if (hresp) begin
          state_d = ST_ERR;
          error_d = 1'b1;
        end else if (hready) begin
          word_taken = 1'b1;
          count_d    = count_q + 16'd1;
          addr_d     = addr_q + ADDR_WIDTH'(4);
          state_d    = pk_last ? ST_DONE : ST_FILL;
          done_d     = pk_last;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= ST_IDLE;
      addr_q   <= BASE_ADDR;
      haddr_q  <= '0;
      hwdata_q <= '0;
      htrans_q <= HTRANS_IDLE;
      hwrite_q <= 1'b0;
      count_q  <= 16'd0;
      done_q   <= 1'b0;
      error_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      haddr_q  <= haddr_d;
      hwdata_q <= hwdata_d;
      htrans_q <= htrans_d;
      hwrite_q <= hwrite_d;
      count_q  <= count_d;
      done_q   <= done_d;
      error_q  <= error_d;
    end
  end

  assign haddr      = haddr_q;
  assign hwdata     = hwdata_q;
  assign htrans     = htrans_q;
  assign hwrite     = hwrite_q;
  assign hsize      = HSIZE_WORD;
  assign hburst     = HBURST_SINGLE;
  assign hprot      = HPROT_DATA;
  assign hmastlock  = 1'b0;
  assign busy       = (state_q == ST_FILL) || (state_q == ST_ADDR) || (state_q == ST_DATA);
  assign done       = done_q;
  assign error      = error_q;
  assign word_count = count_q;

endmodule
